// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned ADR_W   = 32;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned CTI_W   = 3;
  localparam int unsigned BTE_W   = 2;
  localparam int unsigned GRANT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [GRANT_W-1:0] GRANT_NONE = 2'b00;
  localparam logic [GRANT_W-1:0] GRANT_M0   = 2'b01;
  localparam logic [GRANT_W-1:0] GRANT_M1   = 2'b10;

  // One-hot owner encoding for a given arbiter state.
  function automatic logic [GRANT_W-1:0] state_to_grant(input arb_state_t s);
    case (s)
      OWN0:    return GRANT_M0;
      OWN1:    return GRANT_M1;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle; master drives the request side, slave drives the response side.
interface wshb_if;
  import wb_arb_pkg::*;

  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic [ADR_W-1:0]         adr;
  logic [DAT_W-1:0]         dat_ms;
  logic [DAT_W-1:0]         dat_sm;
  logic [SEL_W-1:0]         sel;
  logic [CTI_W-1:0]         cti;
  logic [BTE_W-1:0]         bte;
  logic                     ack;
  logic                     err;
  logic                     rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wb_arbiter_2m.sv
// Round-robin arbiter letting two Wishbone masters share one slave; ownership
// is held for the whole CYC so bursts are never split.
module wb_arbiter_2m
  import wb_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  wshb_if.slave              wb_s0,
  wshb_if.slave              wb_s1,
  wshb_if.master             wb_m,
  output logic [GRANT_W-1:0] grant
);

  arb_state_t         state_q, state_d;
  logic               ptr_q, ptr_d;      // 0: m0 wins a tie, 1: m1 wins a tie
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic               req0, req1;

  assign req0  = wb_s0.cyc;
  assign req1  = wb_s1.cyc;
  assign grant = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= GRANT_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next owner: hand over directly when the owner releases and the other waits.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || !ptr_q)) state_d = OWN0;
        else if (req1)                 state_d = OWN1;
      end
      OWN0:    if (!req0) state_d = req1 ? OWN1 : IDLE;
      OWN1:    if (!req1) state_d = req0 ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == OWN0)      ptr_d = 1'b1;
      else if (state_d == OWN1) ptr_d = 1'b0;
    end
    grant_d = state_to_grant(state_d);
  end

  // Routing mux: owner's request to the slave, slave response only to the owner.
  always_comb begin
    wb_m.cyc     = 1'b0;
    wb_m.stb     = 1'b0;
    wb_m.we      = 1'b0;
    wb_m.adr     = '0;
    wb_m.dat_ms  = '0;
    wb_m.sel     = '0;
    wb_m.cti     = '0;
    wb_m.bte     = '0;
    wb_s0.ack    = 1'b0;
    wb_s0.err    = 1'b0;
    wb_s0.rty    = 1'b0;
    wb_s1.ack    = 1'b0;
    wb_s1.err    = 1'b0;
    wb_s1.rty    = 1'b0;
    wb_s0.dat_sm = wb_m.dat_sm;
    wb_s1.dat_sm = wb_m.dat_sm;
    case (state_q)
      OWN0: begin
        wb_m.cyc    = wb_s0.cyc;
        wb_m.stb    = wb_s0.stb;
        wb_m.we     = wb_s0.we;
        wb_m.adr    = wb_s0.adr;
        wb_m.dat_ms = wb_s0.dat_ms;
        wb_m.sel    = wb_s0.sel;
        wb_m.cti    = wb_s0.cti;
        wb_m.bte    = wb_s0.bte;
        wb_s0.ack   = wb_m.ack;
        wb_s0.err   = wb_m.err;
        wb_s0.rty   = wb_m.rty;
      end
      OWN1: begin
        wb_m.cyc    = wb_s1.cyc;
        wb_m.stb    = wb_s1.stb;
        wb_m.we     = wb_s1.we;
        wb_m.adr    = wb_s1.adr;
        wb_m.dat_ms = wb_s1.dat_ms;
        wb_m.sel    = wb_s1.sel;
        wb_m.cti    = wb_s1.cti;
        wb_m.bte    = wb_s1.bte;
        wb_s1.ack   = wb_m.ack;
        wb_s1.err   = wb_m.err;
        wb_s1.rty   = wb_m.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master to one-slave Wishbone arbiter.
- Lets two masters share one Wishbone slave, typically the on-chip block-RAM controller. Example masters: a CPU data port and a display/DMA reader.
- Grants are round-robin, held for the whole bus cycle (CYC high), so classic and incrementing bursts are never split.
- Sits directly in front of the block-RAM slave interface; the slave is unmodified.

Parameters:
- none. Wishbone widths come from wshb_if: 32-bit data and address, 4-bit sel, 3-bit cti, 2-bit bte.

Ports:
- clk  input  1  system clock; the same clock drives all three interfaces.
- rst  input  1  synchronous, active-high reset.
- wb_s0  wshb_if.slave  -  master 0 port; wins ties after reset.
- wb_s1  wshb_if.slave  -  master 1 port.
- wb_m  wshb_if.master  -  port to the shared slave.
- grant  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle.

Behaviour:
- FSM states: IDLE, OWN0, OWN1, registered on clk. Reset → IDLE, grant = 00, priority pointer = m0.
- Request = cyc of that port. Arbitration is registered: a request sampled high in cycle N makes the owner state valid in N+1. Forwarding starts in N+1.
- Decision from IDLE:
  - One requester: grant it.
  - Both requesting: grant the master named by the priority pointer.
  - No requester: stay in IDLE.
- Pointer update: whenever a grant is issued, the pointer flips to the non-granted master (round-robin).
- Holding and release while OWNx:
  - Stay in OWNx while wb_sx.cyc = 1.
  - When wb_sx.cyc = 0 and the other master requests: go directly to the other OWN state next cycle, with no IDLE bubble.
  - When wb_sx.cyc = 0 and the other master is not requesting: go to IDLE.
- Forwarding while OWNx:
  - Master → slave, combinational: wb_m.cyc, stb, we, adr, dat_ms, sel, cti, bte are taken from wb_sx.
  - Slave → master: wb_sx.ack = wb_m.ack. wb_sx.err and wb_sx.rty follow wb_m the same way.
- Non-owner / IDLE masking:
  - The non-owner gets ack = err = rty = 0.
  - In IDLE, wb_m.cyc = wb_m.stb = 0 and the other wb_m outputs are 0.
- dat_sm: wb_m.dat_sm is broadcast to both masters. It is only valid for the master whose ack is high.
- Slave behaviour is unchanged:
  - Writes are acked in the same cycle as stb.
  - Read ack is registered. For classic cycles (cti = 0) it is one cycle after stb, then low for one cycle.
  - Incrementing bursts (cti = 2, bte = 0) stream one ack per cycle.
  - The arbiter must add no latency to any of these.
- Simultaneous events:
  - Owner drops cyc while the other raises cyc in the same cycle: the other is granted next cycle.
  - Both drop cyc: go to IDLE.
- Mid-cycle stb: stb may fall while cyc stays high. Ownership is kept and wb_m.stb follows the owner (0).
- Reset mid-transaction: next edge → IDLE, wb_m.cyc/stb = 0, pointer = m0. An in-flight registered ack from the slave may appear one cycle later; it is masked and never reaches either master.
- Master protocol: a master must not change adr/we/stb while waiting without deasserting cyc. The arbiter does not check this.

Decomposition:
- Package wb_arb_pkg: typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t. Constants GRANT_NONE/GRANT_M0/GRANT_M1 (2-bit one-hot).
- Arbiter module contains:
  - the FSM and pointer (always_ff);
  - a combinational next-state and routing block (always_comb).
- No sub-module is needed. A 2:1 routing mux inlined with a case on state is the natural form.

Test Plan:
- Single write, m0 alone: cyc/stb/we = 1, adr = 0x10, dat = 0xDEADBEEF, sel = F at cycle 1 → grant = 01 at cycle 2, ack to m0 at cycle 2. Readback via classic read returns 0xDEADBEEF with ack at cycle 3 after grant.
- Contention after reset: both raise cyc at cycle 1 with writes to 0x0 and 0x4 → m0 is granted first (grant = 01). When m0 drops cyc, grant = 10 on the next cycle with no IDLE bubble. Memory holds both words.
- Round-robin fairness: both masters request continuously, each doing 1-word cycles → grant alternates 01, 10, 01, 10; neither master is granted twice in a row.
- Burst integrity: m1 does a 4-beat incrementing read (cti = 2, bte = 0) at 0x20 while m0 requests mid-burst → m1 receives 4 consecutive acks with words 0x20..0x2C. m0 is granted only after m1's cyc falls, and m0 sees no ack during the burst.
- Masking: m1 idle with cyc = 0 while m0 does a read → wb_s1.ack stays 0 throughout, and wb_m never sees m1's adr.
- Reset mid-read: rst = 1 in the cycle m0's classic read stb is accepted → next cycle grant = 00 and wb_m.cyc = 0. Neither master ever sees ack = 1, and a subsequent simultaneous request grants m0 first.
